intcon_ctrl: RTL and testbench

- Interrupt control stage directly downstream of the TMR0 block.
- Latches T0IF from tmr0's t0if, plus RB0/INT edge, RB7:RB4 change and EEPROM write-complete events, into INTCON-style flags.
- Gates the flags with the enables and GIE, and runs the vector request/service handshake with the CPU core.
- Also produces the SLEEP wake-up signal.

---
 rtl/intcon_ctrl.sv | 150 +++++++++++++++
 tb/tb_intcon_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intcon_ctrl.sv
// intcon_ctrl: INTCON-style interrupt flag/enable register, request/service
// handshake with the CPU core, and SLEEP wake-up generation. Asynchronous
// event pins are synchronised into the oscIn domain, and then edge or level
// detected. Each set-event is registered once before it reaches its flag.
module intcon_ctrl #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [12:0] VECTOR_ADDR = 13'h0004
) (
  input  logic        oscIn,
  input  logic        rst,
  input  logic        t0ifIn,
  input  logic        rb0Int,
  input  logic        intedg,
  input  logic [3:0]  rbIn,
  input  logic [3:0]  rbInMask,
  input  logic        portbRead,
  input  logic        eeifIn,
  input  logic        eeifClr,
  input  logic        intconWe,
  input  logic [7:0]  intconWdata,
  input  logic        retfie,
  input  logic        irqAck,
  output logic [7:0]  intconOut,
  output logic        eeifOut,
  output logic        irqReq,
  output logic [12:0] vectorAddr,
  output logic        wakeOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  // Bit positions inside INTCON
  localparam int GIE_B  = 7;
  localparam int EEIE_B = 6;
  localparam int T0IE_B = 5;
  localparam int INTE_B = 4;
  localparam int RBIE_B = 3;
  localparam int T0IF_B = 2;
  localparam int INTF_B = 1;
  localparam int RBIF_B = 0;

  logic [SYNC_STAGES-1:0]      t0_sync_q, t0_sync_d;
  logic [SYNC_STAGES-1:0]      rb0_sync_q, rb0_sync_d;
  logic [SYNC_STAGES-1:0][3:0] rb_sync_q, rb_sync_d;
  logic                        t0_prev_q, t0_prev_d;
  logic                        rb0_prev_q, rb0_prev_d;
  logic [3:0]                  rb_latch_q, rb_latch_d;
  logic                        ev_t0_q, ev_t0_d;
  logic                        ev_int_q, ev_int_d;
  logic                        ev_rb_q, ev_rb_d;
  logic [7:0]                  intcon_q, intcon_d;
  logic                        eeif_q, eeif_d;
  logic                        wake_q, wake_d;
  state_t                      state_q, state_d;

  logic                        t0_synced;
  logic                        rb0_synced;
  logic [3:0]                  rb_synced;
  logic                        pending;
  logic                        vec_entry;

  // Synchroniser shift chains, edge/mismatch detection and the PORTB change latch
  always_comb begin
    t0_sync_d  = {t0_sync_q[SYNC_STAGES-2:0], t0ifIn};
    rb0_sync_d = {rb0_sync_q[SYNC_STAGES-2:0], rb0Int};
    rb_sync_d  = {rb_sync_q[SYNC_STAGES-2:0], rbIn};
    t0_synced  = t0_sync_q[SYNC_STAGES-1];
    rb0_synced = rb0_sync_q[SYNC_STAGES-1];
    rb_synced  = rb_sync_q[SYNC_STAGES-1];
    t0_prev_d  = t0_synced;
    rb0_prev_d = rb0_synced;
    ev_t0_d    = t0_synced & ~t0_prev_q;
    ev_int_d   = intedg ? (rb0_synced & ~rb0_prev_q) : (~rb0_synced & rb0_prev_q);
    ev_rb_d    = |((rb_synced ^ rb_latch_q) & rbInMask);
    rb_latch_d = portbRead ? rb_synced : rb_latch_q;
  end

  // Pending interrupt, vector entry decision and the INTCON/EEIF next values
  always_comb begin
    pending = (intcon_q[T0IF_B] & intcon_q[T0IE_B]) |
              (intcon_q[INTF_B] & intcon_q[INTE_B]) |
              (intcon_q[RBIF_B] & intcon_q[RBIE_B]) |
              (eeif_q & intcon_q[EEIE_B]);
    vec_entry = (state_q == IDLE) && intcon_q[GIE_B] && pending;
    intcon_d  = intcon_q;
    if (intconWe) intcon_d = intconWdata;
    if (ev_t0_q)  intcon_d[T0IF_B] = 1'b1;
    if (ev_int_q) intcon_d[INTF_B] = 1'b1;
    if (ev_rb_q)  intcon_d[RBIF_B] = 1'b1;
    if (retfie && (state_q == SVC)) intcon_d[GIE_B] = 1'b1;
    if (vec_entry) intcon_d[GIE_B] = 1'b0;
    eeif_d = (eeif_q & ~eeifClr) | eeifIn;
    wake_d = pending;
  end

  // Request/service handshake: a request, once raised, is held until acknowledged
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (vec_entry) state_d = REQ;
      REQ:     if (irqAck)    state_d = SVC;
      SVC:     if (retfie)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge oscIn) begin
    if (rst) begin
      t0_sync_q  <= '0;
      rb0_sync_q <= '0;
      rb_sync_q  <= '0;
      t0_prev_q  <= 1'b0;
      rb0_prev_q <= 1'b0;
      rb_latch_q <= 4'h0;
      ev_t0_q    <= 1'b0;
      ev_int_q   <= 1'b0;
      ev_rb_q    <= 1'b0;
      intcon_q   <= 8'h00;
      eeif_q     <= 1'b0;
      wake_q     <= 1'b0;
      state_q    <= IDLE;
    end else begin
      t0_sync_q  <= t0_sync_d;
      rb0_sync_q <= rb0_sync_d;
      rb_sync_q  <= rb_sync_d;
      t0_prev_q  <= t0_prev_d;
      rb0_prev_q <= rb0_prev_d;
      rb_latch_q <= rb_latch_d;
      ev_t0_q    <= ev_t0_d;
      ev_int_q   <= ev_int_d;
      ev_rb_q    <= ev_rb_d;
      intcon_q   <= intcon_d;
      eeif_q     <= eeif_d;
      wake_q     <= wake_d;
      state_q    <= state_d;
    end
  end

  assign intconOut  = intcon_q;
  assign eeifOut    = eeif_q;
  assign irqReq     = (state_q == REQ);
  assign vectorAddr = VECTOR_ADDR;
  assign wakeOut    = wake_q;

endmodule

// File: tb/tb_intcon_ctrl.sv
// tb_intcon_ctrl: directed test of intcon_ctrl with hand-computed expectations.
module tb_intcon_ctrl;

  logic        oscIn = 1'b0;
  logic        rst;
  logic        t0ifIn;
  logic        rb0Int;
  logic        intedg;
  logic [3:0]  rbIn;
  logic [3:0]  rbInMask;
  logic        portbRead;
  logic        eeifIn;
  logic        eeifClr;
  logic        intconWe;
  logic [7:0]  intconWdata;
  logic        retfie;
  logic        irqAck;
  logic [7:0]  intconOut;
  logic        eeifOut;
  logic        irqReq;
  logic [12:0] vectorAddr;
  logic        wakeOut;

  int checks = 0;
  int errors = 0;

  intcon_ctrl #(.SYNC_STAGES(2), .VECTOR_ADDR(13'h0004)) dut (
    .oscIn(oscIn), .rst(rst), .t0ifIn(t0ifIn), .rb0Int(rb0Int), .intedg(intedg),
    .rbIn(rbIn), .rbInMask(rbInMask), .portbRead(portbRead), .eeifIn(eeifIn),
    .eeifClr(eeifClr), .intconWe(intconWe), .intconWdata(intconWdata),
    .retfie(retfie), .irqAck(irqAck), .intconOut(intconOut), .eeifOut(eeifOut),
    .irqReq(irqReq), .vectorAddr(vectorAddr), .wakeOut(wakeOut)
  );

  // 10 ns clock
  always #5 oscIn = ~oscIn;

  // Advance n rising edges; inputs change and outputs are sampled 1 ns after the edge
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge oscIn);
    #1;
  endtask

  // One-cycle INTCON write
  task automatic writeIntcon(input logic [7:0] data);
    intconWe    = 1'b1;
    intconWdata = data;
    applyStimulus(1);
    intconWe    = 1'b0;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Directed scenario sequence
  initial begin
    rst = 1'b1; t0ifIn = 1'b0; rb0Int = 1'b0; intedg = 1'b0; rbIn = 4'h0;
    rbInMask = 4'h0; portbRead = 1'b0; eeifIn = 1'b0; eeifClr = 1'b0;
    intconWe = 1'b0; intconWdata = 8'h00; retfie = 1'b0; irqAck = 1'b0;
    applyStimulus(2);
    rst = 1'b0;

    $display("[TB] reset and idle");
    checkOutput("reset_intcon", intconOut, 16'h00);
    checkOutput("reset_eeif", eeifOut, 16'h0);
    checkOutput("reset_irq", irqReq, 16'h0);
    checkOutput("reset_wake", wakeOut, 16'h0);
    checkOutput("vector_addr", vectorAddr, 16'h0004);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1);
      checkOutput("idle_state", {intconOut, 6'b0, irqReq, wakeOut}, 16'h0000);
    end

    $display("[TB] T0IF interrupt, vector, service, back-to-back");
    writeIntcon(8'hA0);
    checkOutput("t0_write", intconOut, 16'hA0);
    t0ifIn = 1'b1;
    applyStimulus(3);
    t0ifIn = 1'b0;
    checkOutput("t0_not_yet", intconOut, 16'hA0);
    applyStimulus(1);
    checkOutput("t0_flag_set", intconOut, 16'hA4);
    checkOutput("t0_no_irq_yet", irqReq, 16'h0);
    applyStimulus(1);
    checkOutput("t0_gie_clr", intconOut, 16'h24);
    checkOutput("t0_irq", irqReq, 16'h1);
    checkOutput("t0_wake", wakeOut, 16'h1);
    irqAck = 1'b1;
    applyStimulus(1);
    irqAck = 1'b0;
    checkOutput("svc_irq_low", irqReq, 16'h0);
    applyStimulus(3);
    checkOutput("svc_no_new_req", irqReq, 16'h0);
    checkOutput("svc_intcon", intconOut, 16'h24);
    retfie = 1'b1;
    applyStimulus(1);
    retfie = 1'b0;
    checkOutput("retfie_gie", intconOut, 16'hA4);
    checkOutput("retfie_irq", irqReq, 16'h0);
    applyStimulus(1);
    checkOutput("b2b_irq", irqReq, 16'h1);
    checkOutput("b2b_gie_clr", intconOut, 16'h24);
    writeIntcon(8'h00);
    checkOutput("req_write", intconOut, 16'h00);
    checkOutput("req_committed", irqReq, 16'h1);
    applyStimulus(2);
    checkOutput("req_still", irqReq, 16'h1);
    irqAck = 1'b1;
    applyStimulus(1);
    irqAck = 1'b0;
    retfie = 1'b1; intconWe = 1'b1; intconWdata = 8'h10;
    applyStimulus(1);
    retfie = 1'b0; intconWe = 1'b0;
    checkOutput("retfie_with_write", intconOut, 16'h90);
    checkOutput("retfie_idle", irqReq, 16'h0);
    applyStimulus(1);
    checkOutput("idle_no_pending", irqReq, 16'h0);
    writeIntcon(8'h00);
    irqAck = 1'b1;
    applyStimulus(1);
    irqAck = 1'b0;
    checkOutput("ack_in_idle", irqReq, 16'h0);
    retfie = 1'b1;
    applyStimulus(1);
    retfie = 1'b0;
    checkOutput("retfie_in_idle", intconOut, 16'h00);

    $display("[TB] INTF edge selection");
    writeIntcon(8'h10);
    rb0Int = 1'b1;
    applyStimulus(5);
    checkOutput("intf_rise_ignored", intconOut, 16'h10);
    rb0Int = 1'b0;
    applyStimulus(3);
    checkOutput("intf_not_yet", intconOut, 16'h10);
    applyStimulus(1);
    checkOutput("intf_fall_set", intconOut, 16'h12);
    checkOutput("intf_wake_lag", wakeOut, 16'h0);
    applyStimulus(1);
    checkOutput("intf_wake", wakeOut, 16'h1);
    checkOutput("intf_no_irq", irqReq, 16'h0);
    writeIntcon(8'h10);
    rb0Int = 1'b1;
    applyStimulus(5);
    intedg = 1'b1;
    rb0Int = 1'b0;
    applyStimulus(6);
    checkOutput("intf_fall_ignored", intconOut, 16'h10);
    writeIntcon(8'h00);

    $display("[TB] RB change detection");
    rbInMask = 4'b1010;
    writeIntcon(8'h08);
    rbIn = 4'b0001;
    applyStimulus(6);
    checkOutput("rb_masked", intconOut, 16'h08);
    rbIn = 4'b0011;
    applyStimulus(3);
    checkOutput("rb_not_yet", intconOut, 16'h08);
    applyStimulus(1);
    checkOutput("rb_set", intconOut, 16'h09);
    writeIntcon(8'h08);
    checkOutput("rb_clear_lost", intconOut, 16'h09);
    applyStimulus(2);
    checkOutput("rb_persist", intconOut, 16'h09);
    portbRead = 1'b1;
    applyStimulus(1);
    portbRead = 1'b0;
    applyStimulus(2);
    writeIntcon(8'h08);
    checkOutput("rb_clear", intconOut, 16'h08);
    applyStimulus(3);
    checkOutput("rb_stays_clear", intconOut, 16'h08);
    rbInMask = 4'h0;
    rbIn = 4'h0;
    writeIntcon(8'h00);

    $display("[TB] same-cycle conflicts");
    t0ifIn = 1'b1;
    applyStimulus(3);
    checkOutput("conf_pre", intconOut, 16'h00);
    writeIntcon(8'h00);
    checkOutput("conf_t0_wins", intconOut, 16'h04);
    t0ifIn = 1'b0;
    applyStimulus(4);
    writeIntcon(8'h00);
    eeifIn = 1'b1; eeifClr = 1'b1;
    applyStimulus(1);
    checkOutput("conf_eeif_wins", eeifOut, 16'h1);
    eeifIn = 1'b0;
    applyStimulus(1);
    eeifClr = 1'b0;
    checkOutput("eeif_clear", eeifOut, 16'h0);
    eeifIn = 1'b1;
    applyStimulus(1);
    eeifIn = 1'b0;
    applyStimulus(2);
    checkOutput("eeif_hold", eeifOut, 16'h1);
    eeifClr = 1'b1;
    applyStimulus(1);
    eeifClr = 1'b0;

    $display("[TB] reset in REQ and SVC");
    writeIntcon(8'hC0);
    eeifIn = 1'b1;
    applyStimulus(1);
    eeifIn = 1'b0;
    applyStimulus(1);
    checkOutput("ee_req", irqReq, 16'h1);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    checkOutput("rst_req_irq", irqReq, 16'h0);
    checkOutput("rst_req_intcon", intconOut, 16'h00);
    checkOutput("rst_req_eeif", eeifOut, 16'h0);
    checkOutput("rst_req_wake", wakeOut, 16'h0);
    applyStimulus(3);
    checkOutput("rst_req_quiet", irqReq, 16'h0);
    writeIntcon(8'hC0);
    eeifIn = 1'b1;
    applyStimulus(1);
    eeifIn = 1'b0;
    applyStimulus(1);
    irqAck = 1'b1;
    applyStimulus(1);
    irqAck = 1'b0;
    checkOutput("svc_pre_rst", intconOut, 16'h40);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    checkOutput("rst_svc_intcon", intconOut, 16'h00);
    checkOutput("rst_svc_irq", irqReq, 16'h0);
    retfie = 1'b1;
    applyStimulus(1);
    retfie = 1'b0;
    checkOutput("rst_svc_idle", intconOut, 16'h00);
    writeIntcon(8'h40);
    eeifIn = 1'b1;
    applyStimulus(1);
    eeifIn = 1'b0;
    applyStimulus(3);
    checkOutput("no_gie_no_irq", irqReq, 16'h0);
    checkOutput("no_gie_wake", wakeOut, 16'h1);
    writeIntcon(8'hC0);
    applyStimulus(1);
    checkOutput("reenabled_irq", irqReq, 16'h1);
    checkOutput("reenabled_gie", intconOut, 16'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
